// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper
//   Six-digit BCD time-of-day counter (HH:MM:SS) for the 7-segment display path.
//   Contains a 1 Hz prescaler, a cascaded BCD seconds/minutes/hours counter and
//   a small set-mode FSM driven by two debounced push-button levels.
//
//   Build option: define CLOCK_12H_EN for a 12 hour clock (hours 12,01..11 with
//   a PM flag). Left undefined, the clock counts 00..23 and pm_o stays 0.
//
// Ports
//   clk_i   in   1  system clock
//   rst_i   in   1  asynchronous active-high reset
//   mode_i  in   1  debounced level, rising edge steps RUN -> SET_HR -> SET_MIN -> RUN
//   inc_i   in   1  debounced level, rising edge increments the field being set
//   bin0    out  4  seconds units
//   bin1    out  4  seconds tens
//   bin2    out  4  minutes units
//   bin3    out  4  minutes tens
//   bin4    out  4  hours units
//   bin5    out  4  hours tens
//   edit_o  out  2  00 RUN, 01 SET_HR, 10 SET_MIN
//   tick_o  out  1  one-cycle pulse on every 1 Hz increment while running
//   pm_o    out  1  PM flag (12 hour build only)

module bcd_timekeeper #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mode_i,
  input  logic       inc_i,
  output logic [3:0] bin0,
  output logic [3:0] bin1,
  output logic [3:0] bin2,
  output logic [3:0] bin3,
  output logic [3:0] bin4,
  output logic [3:0] bin5,
  output logic [1:0] edit_o,
  output logic       tick_o,
  output logic       pm_o
);

  localparam int PW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_FREQ_HZ - 1);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HR_RESET = 8'h12;
`else
  localparam logic [7:0] HR_RESET = 8'h00;
`endif

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    sec, sec_n;
  logic [7:0]    min, min_n;
  logic [7:0]    hr, hr_n;
  logic          pm, pm_n;
  logic          tick, tick_n;
  logic          mode_prev, inc_prev;
  logic          mode_edge, inc_edge;
  logic [8:0]    hr_step;

  // Seconds and minutes share one BCD step: 59 wraps to 00, x9 carries into tens.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Hour step returns {hours, pm}. In the 12 hour build the flag flips only on
  // 11 -> 12; in the 24 hour build it is passed through untouched (always 0).
  function automatic logic [8:0] hr_inc(input logic [7:0] h, input logic p);
`ifdef CLOCK_12H_EN
    if (h == 8'h12)
      return {8'h01, p};
    else if (h == 8'h11)
      return {8'h12, ~p};
`else
    if (h == 8'h23)
      return {8'h00, p};
`endif
    else if (h[3:0] == 4'd9)
      return {h[7:4] + 4'd1, 4'd0, p};
    else
      return {h[7:4], h[3:0] + 4'd1, p};
  endfunction

  // Rising edges are the current level against last cycle's level; the previous
  // registers reset to 0 so a button held through reset still counts once.
  assign mode_edge = mode_i & ~mode_prev;
  assign inc_edge  = inc_i & ~inc_prev;
  assign hr_step   = hr_inc(hr, pm);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= mode_i;
      inc_prev  <= inc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= RUN;
    else
      state <= state_n;
  end

  // Datapath registers; tick is registered so it lines up with the new seconds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc <= '0;
      sec   <= 8'h00;
      min   <= 8'h00;
      hr    <= HR_RESET;
      pm    <= 1'b0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_n;
      sec   <= sec_n;
      min   <= min_n;
      hr    <= hr_n;
      pm    <= pm_n;
      tick  <= tick_n;
    end
  end

  // Next-state and next-time logic. A mode edge always takes priority, so an
  // inc edge (or a prescaler terminal count) in the same cycle is dropped.
  always_comb begin
    state_n = state;
    presc_n = presc;
    sec_n   = sec;
    min_n   = min;
    hr_n    = hr;
    pm_n    = pm;
    tick_n  = 1'b0;
    case (state)
      RUN: begin
        if (mode_edge) begin
          state_n = SET_HR;
          presc_n = '0;
        end else if (presc == TERM) begin
          presc_n = '0;
          tick_n  = 1'b1;
          sec_n   = bcd_inc59(sec);
          if (sec == 8'h59) begin
            min_n = bcd_inc59(min);
            if (min == 8'h59) begin
              hr_n = hr_step[8:1];
              pm_n = hr_step[0];
            end
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      SET_HR: begin
        if (mode_edge) begin
          state_n = SET_MIN;
        end else if (inc_edge) begin
          hr_n = hr_step[8:1];
          pm_n = hr_step[0];
        end
      end
      SET_MIN: begin
        if (mode_edge) begin
          state_n = RUN;
          sec_n   = 8'h00;
          presc_n = '0;
        end else if (inc_edge) begin
          min_n = bcd_inc59(min);
        end
      end
      default: begin
        state_n = RUN;
        presc_n = '0;
      end
    endcase
  end

  assign bin0   = sec[3:0];
  assign bin1   = sec[7:4];
  assign bin2   = min[3:0];
  assign bin3   = min[7:4];
  assign bin4   = hr[3:0];
  assign bin5   = hr[7:4];
  assign edit_o = state;
  assign tick_o = tick;
  assign pm_o   = pm;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb_bcd_timekeeper
//   Self-checking bench for bcd_timekeeper with CLK_FREQ_HZ = 4. A reference
//   model keeps the time as seconds-of-day and derives the digits arithmetically;
//   a compare process checks every cycle, and directed scenarios pin literal
//   values. Define CLOCK_12H_EN to exercise the 12 hour build.

module tb_bcd_timekeeper;

  localparam int FREQ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_i = 1'b0;
  logic       inc_i = 1'b0;
  logic [3:0] bin0, bin1, bin2, bin3, bin4, bin5;
  logic [1:0] edit_o;
  logic       tick_o;
  logic       pm_o;

  int checks = 0;
  int failures = 0;

  bcd_timekeeper #(.CLK_FREQ_HZ(FREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mode_i(mode_i),
    .inc_i (inc_i),
    .bin0  (bin0),
    .bin1  (bin1),
    .bin2  (bin2),
    .bin3  (bin3),
    .bin4  (bin4),
    .bin5  (bin5),
    .edit_o(edit_o),
    .tick_o(tick_o),
    .pm_o  (pm_o)
  );

  always #5 clk = ~clk;

  // Reference model: time of day in seconds, 0 = midnight (12 AM in 12 h mode).
  int m_tod = 0;
  int m_pre = 0;
  int m_mode = 0;
  bit m_mprev = 0;
  bit m_iprev = 0;
  bit m_tick = 0;

  always @(posedge clk or posedge rst) begin
    bit me, ie;
    int h, m, s;
    if (rst) begin
      m_tod = 0; m_pre = 0; m_mode = 0;
      m_mprev = 0; m_iprev = 0; m_tick = 0;
    end else begin
      me = mode_i && !m_mprev;
      ie = inc_i && !m_iprev;
      m_mprev = mode_i;
      m_iprev = inc_i;
      m_tick = 0;
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      s = m_tod % 60;
      if (m_mode == 0) begin
        if (me) begin
          m_mode = 1; m_pre = 0;
        end else if (m_pre == FREQ - 1) begin
          m_pre = 0; m_tick = 1; m_tod = (m_tod + 1) % 86400;
        end else begin
          m_pre++;
        end
      end else if (m_mode == 1) begin
        if (me) m_mode = 2;
        else if (ie) m_tod = ((h + 1) % 24) * 3600 + m * 60 + s;
      end else begin
        if (me) begin
          m_mode = 0; m_pre = 0; m_tod = h * 3600 + m * 60;
        end else if (ie) begin
          m_tod = h * 3600 + ((m + 1) % 60) * 60 + s;
        end
      end
    end
  end

  function automatic int disp_hour(input int tod);
    int h24;
    h24 = tod / 3600;
`ifdef CLOCK_12H_EN
    return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    return h24;
`endif
  endfunction

  function automatic bit model_pm(input int tod);
`ifdef CLOCK_12H_EN
    return (tod / 3600) >= 12;
`else
    return 1'b0;
`endif
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int eh, em, es;
    if (!rst) begin
      eh = disp_hour(m_tod);
      em = (m_tod / 60) % 60;
      es = m_tod % 60;
      checks++;
      if (bin5 != 4'(eh / 10) || bin4 != 4'(eh % 10) || bin3 != 4'(em / 10) ||
          bin2 != 4'(em % 10) || bin1 != 4'(es / 10) || bin0 != 4'(es % 10) ||
          edit_o != 2'(m_mode) || tick_o != m_tick || pm_o != model_pm(m_tod)) begin
        failures++;
        $display("[TB] FAIL model t=%0t got %0d%0d:%0d%0d:%0d%0d edit=%0d tick=%0b pm=%0b want %02d:%02d:%02d edit=%0d tick=%0b pm=%0b",
                 $time, bin5, bin4, bin3, bin2, bin1, bin0, edit_o, tick_o, pm_o,
                 eh, em, es, m_mode, m_tick, model_pm(m_tod));
      end
    end
  end

  task automatic applyStimulus(input bit m, input bit i);
    @(negedge clk);
    mode_i = m;
    inc_i  = i;
    @(negedge clk);
    mode_i = 1'b0;
    inc_i  = 1'b0;
  endtask

  task automatic incTimes(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input int hh, input int mm, input int ss,
                             input int ed, input bit pm);
    int ah, am, as;
    ah = bin5 * 10 + bin4;
    am = bin3 * 10 + bin2;
    as = bin1 * 10 + bin0;
    checks++;
    if (ah != hh || am != mm || as != ss || edit_o != 2'(ed) || pm_o != pm) begin
      failures++;
      $display("[TB] FAIL %s got %02d:%02d:%02d edit=%0d pm=%0b want %02d:%02d:%02d edit=%0d pm=%0b",
               name, ah, am, as, edit_o, pm_o, hh, mm, ss, ed, pm);
    end
  endtask

  task automatic waitTicks(input string name, input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * FREQ + 16) begin
      @(negedge clk);
      cyc++;
      if (tick_o) seen++;
    end
    checks++;
    if (seen < n) begin
      failures++;
      $display("[TB] FAIL %s ticks got %0d want %0d", name, seen, n);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    mode_i = 1'b0;
    inc_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef CLOCK_12H_EN
    checkOutput("reset12", 12, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    incTimes(11);
    applyStimulus(1'b1, 1'b0);
    incTimes(59);
    applyStimulus(1'b1, 1'b0);
    checkOutput("preset1159", 11, 59, 0, 0, 1'b0);
    waitTicks("to1159_58", 58);
    checkOutput("t1159_58", 11, 59, 58, 0, 1'b0);
    waitTicks("to1200", 2);
    checkOutput("noon", 12, 0, 0, 0, 1'b1);
    waitTicks("to1259_59", 3599);
    checkOutput("t1259_59", 12, 59, 59, 0, 1'b1);
    waitTicks("to0100", 1);
    checkOutput("one_pm", 1, 0, 0, 0, 1'b1);
`else
    // Free running from reset: tick every 4th cycle, one cycle wide.
    checkOutput("reset", 0, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checks++;
      if (tick_o != (i % 4 == 0)) begin
        failures++;
        $display("[TB] FAIL tick_cycle%0d got %0b want %0b", i, tick_o, (i % 4 == 0));
      end
    end
    checkOutput("run12", 0, 0, 3, 0, 1'b0);

    // Preset 23:59 and roll over midnight.
    doReset();
    applyStimulus(1'b1, 1'b0);
    incTimes(23);
    applyStimulus(1'b1, 1'b0);
    incTimes(59);
    applyStimulus(1'b1, 1'b0);
    waitTicks("to235959", 59);
    checkOutput("t235959", 23, 59, 59, 0, 1'b0);
    waitTicks("midnight", 1);
    checkOutput("midnight", 0, 0, 0, 0, 1'b0);

    // Field setting: hours then minutes with wrap and no carry.
    doReset();
    applyStimulus(1'b1, 1'b0);
    incTimes(5);
    checkOutput("sethr5", 5, 0, 0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    incTimes(61);
    checkOutput("setmin61", 5, 1, 0, 2, 1'b0);

    // Simultaneous mode and inc in SET_HR: mode wins.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("backto_sethr", 5, 1, 0, 1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("modewins", 5, 1, 0, 2, 1'b0);
    applyStimulus(1'b1, 1'b0);

    // Async reset in SET_MIN at 10:42:17.
    doReset();
    applyStimulus(1'b1, 1'b0);
    incTimes(10);
    applyStimulus(1'b1, 1'b0);
    incTimes(42);
    applyStimulus(1'b1, 1'b0);
    waitTicks("to104217", 17);
    checkOutput("t104217", 10, 42, 17, 0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("setmin104217", 10, 42, 17, 2, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("asyncreset", 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
`endif

    // Randomised button activity checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      mode_i = ($urandom_range(0, 99) < 3);
      inc_i  = ($urandom_range(0, 99) < 40);
    end
    @(negedge clk);
    mode_i = 1'b0;
    inc_i  = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
